// File: rtl/miriscv_dbus_pkg.sv
// Shared definitions for the data-side bus slave: default base addresses,
// timer register word offsets, CTRL bit positions, decode select type and
// a byte-lane merge helper used by every byte-enabled register.
package miriscv_dbus_pkg;

    localparam int unsigned DBUS_DW = 32;
    localparam int unsigned DBUS_BW = DBUS_DW / 8;

    localparam logic [31:0] DBUS_RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] DBUS_TMR_BASE = 32'h8000_0000;

    // Timer register word offsets (address bits [3:2])
    localparam int unsigned TMR_OFS_W        = 2;
    localparam logic [1:0]  TMR_OFS_MTIME    = 2'd0;
    localparam logic [1:0]  TMR_OFS_MTIMECMP = 2'd1;
    localparam logic [1:0]  TMR_OFS_CTRL     = 2'd2;
    localparam logic [1:0]  TMR_OFS_RSVD     = 2'd3;

    // CTRL register bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_PEND_BIT = 1;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_TMR,
        SEL_NONE
    } dbus_sel_t;

    // One LSU access as seen by this slave
    typedef struct packed {
        logic               req;
        logic               we;
        logic [DBUS_BW-1:0] be;
        logic [31:0]        addr;
        logic [DBUS_DW-1:0] wdata;
    } dbus_req_t;

    // Replace the enabled byte lanes of old_w with those of new_w
    function automatic logic [DBUS_DW-1:0] be_merge(
        input logic [DBUS_DW-1:0] old_w,
        input logic [DBUS_DW-1:0] new_w,
        input logic [DBUS_BW-1:0] be
    );
        logic [DBUS_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(DBUS_BW); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/miriscv_dbus_timer.sv
// Memory-mapped machine timer: MTIME counter, MTIMECMP compare, CTRL (EN,
// PEND) and the registered interrupt request.
// Ports:
//   clk_i, arstn_i   clock, asynchronous active-high reset
//   i_req, i_we      access strobe / write select (already decoded to timer)
//   i_be             byte lanes to write
//   i_offset         register word offset
//   i_wdata          write data
//   o_rdata_c        combinational read data (pre-edge register values)
//   o_irq            timer interrupt request, PEND & EN, registered
module miriscv_dbus_timer
    import miriscv_dbus_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [DBUS_BW-1:0]   i_be,
    input  logic [TMR_OFS_W-1:0] i_offset,
    input  logic [DBUS_DW-1:0]   i_wdata,
    output logic [DBUS_DW-1:0]   o_rdata_c,
    output logic                 o_irq
);

    logic [DBUS_DW-1:0] r_mtime;
    logic [DBUS_DW-1:0] r_mtimecmp;
    logic               r_en;
    logic               r_pend;
    logic               r_irq;

    logic [DBUS_DW-1:0] w_mtime_nxt;
    logic [DBUS_DW-1:0] w_mtimecmp_nxt;
    logic               w_en_nxt;
    logic               w_pend_nxt;

    // Next-state: increment first, then written lanes override it; a PEND
    // set event is applied last so it beats a same-cycle clear.
    always_comb begin
        w_mtime_nxt    = r_en ? (r_mtime + 32'd1) : r_mtime;
        w_mtimecmp_nxt = r_mtimecmp;
        w_en_nxt       = r_en;
        w_pend_nxt     = r_pend;
        if (i_req && i_we) begin
            case (i_offset)
                TMR_OFS_MTIME:    w_mtime_nxt    = be_merge(w_mtime_nxt, i_wdata, i_be);
                TMR_OFS_MTIMECMP: w_mtimecmp_nxt = be_merge(r_mtimecmp, i_wdata, i_be);
                TMR_OFS_CTRL: begin
                    if (i_be[0]) begin
                        w_en_nxt = i_wdata[CTRL_EN_BIT];
                        if (i_wdata[CTRL_PEND_BIT]) begin
                            w_pend_nxt = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (r_en && (r_mtime == r_mtimecmp)) begin
            w_pend_nxt = 1'b1;
        end
    end

    // Timer state and irq registers
    always_ff @(posedge clk_i or posedge arstn_i) begin
        if (arstn_i) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_en       <= 1'b0;
            r_pend     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_en       <= w_en_nxt;
            r_pend     <= w_pend_nxt;
            r_irq      <= w_pend_nxt & w_en_nxt;
        end
    end

    // Register read mux
    always_comb begin
        o_rdata_c = '0;
        case (i_offset)
            TMR_OFS_MTIME:    o_rdata_c = r_mtime;
            TMR_OFS_MTIMECMP: o_rdata_c = r_mtimecmp;
            TMR_OFS_CTRL: begin
                o_rdata_c[CTRL_EN_BIT]   = r_en;
                o_rdata_c[CTRL_PEND_BIT] = r_pend;
            end
            TMR_OFS_RSVD:     o_rdata_c = '0;
            default:          o_rdata_c = '0;
        endcase
    end

    assign o_irq = r_irq;

endmodule

// File: rtl/miriscv_data_bus.sv
// Data-side bus slave behind the LSU: decodes each access to a byte-enabled
// data RAM or the machine timer, returns read data one cycle later and flags
// unmapped accesses.
// Ports:
//   clk_i, arstn_i   clock, asynchronous active-high reset
//   data_req_i       access strobe (one cycle)
//   data_we_i        1 = write, 0 = read
//   data_be_i        byte lanes to write
//   data_addr_i      word address (bits [1:0] ignored)
//   data_wdata_i     lane-replicated write data
//   data_rdata_o     registered read data
//   timer_irq_o      timer interrupt request (level)
//   bus_err_o        one-cycle pulse after an unmapped access
module miriscv_data_bus
    import miriscv_dbus_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = DBUS_RAM_BASE,
    parameter logic [31:0] TMR_BASE  = DBUS_TMR_BASE
)(
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic               data_req_i,
    input  logic               data_we_i,
    input  logic [DBUS_BW-1:0] data_be_i,
    input  logic [31:0]        data_addr_i,
    input  logic [DBUS_DW-1:0] data_wdata_i,
    output logic [DBUS_DW-1:0] data_rdata_o,
    output logic               timer_irq_o,
    output logic               bus_err_o
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

    dbus_req_t          w_acc;
    dbus_sel_t          w_sel;
    logic [RAM_AW-1:0]  w_word;
    logic [DBUS_DW-1:0] w_tmr_rdata;
    logic               w_tmr_irq;
    logic               w_unused;

    logic [DBUS_DW-1:0] r_mem [RAM_WORDS];
    logic [DBUS_DW-1:0] r_rdata;
    logic               r_bus_err;

    assign w_acc = '{req:   data_req_i,
                     we:    data_we_i,
                     be:    data_be_i,
                     addr:  data_addr_i,
                     wdata: data_wdata_i};

    // Byte offset within the word is meaningless on this word-aligned bus
    assign w_unused = ^w_acc.addr[1:0];

    assign w_word = w_acc.addr[2 +: RAM_AW];

    // Address decode, RAM window takes priority if the windows ever overlap
    always_comb begin
        w_sel = SEL_NONE;
        if (w_acc.addr[31:2+RAM_AW] == RAM_BASE[31:2+RAM_AW]) begin
            w_sel = SEL_RAM;
        end else if (w_acc.addr[31:4] == TMR_BASE[31:4]) begin
            w_sel = SEL_TMR;
        end
    end

    miriscv_dbus_timer u_timer (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .i_req     (w_acc.req && (w_sel == SEL_TMR)),
        .i_we      (w_acc.we),
        .i_be      (w_acc.be),
        .i_offset  (w_acc.addr[3:2]),
        .i_wdata   (w_acc.wdata),
        .o_rdata_c (w_tmr_rdata),
        .o_irq     (w_tmr_irq)
    );

    // Data RAM write port; contents are not reset and a write coinciding
    // with reset is discarded
    always_ff @(posedge clk_i) begin
        if (!arstn_i && w_acc.req && w_acc.we && (w_sel == SEL_RAM)) begin
            for (int i = 0; i < int'(DBUS_BW); i++) begin
                if (w_acc.be[i]) begin
                    r_mem[w_word][8*i +: 8] <= w_acc.wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read data and bus error; rdata holds when no read occurs
    always_ff @(posedge clk_i or posedge arstn_i) begin
        if (arstn_i) begin
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_acc.req && (w_sel == SEL_NONE);
            if (w_acc.req && !w_acc.we) begin
                case (w_sel)
                    SEL_RAM:  r_rdata <= r_mem[w_word];
                    SEL_TMR:  r_rdata <= w_tmr_rdata;
                    default:  r_rdata <= '0;
                endcase
            end
        end
    end

    assign data_rdata_o = r_rdata;
    assign timer_irq_o  = w_tmr_irq;
    assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_miriscv_data_bus.sv
// Self-checking bench for miriscv_data_bus: directed steps plus a random
// phase, every cycle compared against a behavioural model of the slave.
module tb_miriscv_data_bus;

    localparam logic [31:0] TMR = 32'h8000_0000;

    logic        clk;
    logic        arstn;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_mem [int];
    logic [31:0] m_mtime;
    logic [31:0] m_cmp;
    logic        m_en;
    logic        m_pend;
    logic [31:0] e_rdata;
    logic        e_irq;
    logic        e_err;

    miriscv_data_bus dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .data_req_i   (req),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_addr_i  (addr),
        .data_wdata_i (wdata),
        .data_rdata_o (rdata),
        .timer_irq_o  (irq),
        .bus_err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime = 32'h0;
        m_cmp   = 32'hFFFF_FFFF;
        m_en    = 1'b0;
        m_pend  = 1'b0;
        e_rdata = 32'h0;
        e_irq   = 1'b0;
        e_err   = 1'b0;
        m_mem.delete();
    endtask

    // One clock edge of the slave as described by its register rules
    task automatic model_step(input logic r, input logic w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        logic [31:0] nt;
        logic [31:0] nc;
        logic        ne;
        logic        np;
        int          widx;
        mask  = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        nt    = m_en ? m_mtime + 32'd1 : m_mtime;
        nc    = m_cmp;
        ne    = m_en;
        np    = m_pend;
        e_err = 1'b0;
        if (r) begin
            if (a[31:12] == 20'h0) begin
                widx = int'(a[11:2]);
                if (w) begin
                    m_mem[widx] = ((m_mem.exists(widx) ? m_mem[widx] : 32'h0) & ~mask) | (d & mask);
                end else begin
                    e_rdata = m_mem.exists(widx) ? m_mem[widx] : 32'hxxxx_xxxx;
                end
            end else if (a[31:4] == TMR[31:4]) begin
                case (a[3:2])
                    2'd0: if (w) nt = (nt & ~mask) | (d & mask); else e_rdata = m_mtime;
                    2'd1: if (w) nc = (m_cmp & ~mask) | (d & mask); else e_rdata = m_cmp;
                    2'd2: begin
                        if (w) begin
                            if (b[0]) begin
                                ne = d[0];
                                if (d[1]) np = 1'b0;
                            end
                        end else begin
                            e_rdata = {30'h0, m_pend, m_en};
                        end
                    end
                    default: if (!w) e_rdata = 32'h0;
                endcase
            end else begin
                e_err = 1'b1;
                if (!w) e_rdata = 32'h0;
            end
        end
        if (m_en && (m_mtime == m_cmp)) np = 1'b1;
        m_mtime = nt;
        m_cmp   = nc;
        m_en    = ne;
        m_pend  = np;
        e_irq   = np & ne;
    endtask

    task automatic step(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
        req   = r;
        we    = w;
        be    = b;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_step(r, w, b, a, d);
        #1;
        check("rdata", rdata, e_rdata);
        check("irq", 32'(irq), 32'(e_irq));
        check("bus_err", 32'(err), 32'(e_err));
        req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        step(1'b1, 1'b1, b, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b0, 4'($urandom), a, $urandom);
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom);
    endtask

    initial begin
        logic        found;
        logic [31:0] ra;
        int          kind;

        arstn = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        arstn = 1'b0;

        // RAM full write and byte-lane merges
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(32'h10);
        check("ram_full", rdata, 32'hDEAD_BEEF);
        wr(32'h10, 32'h5555_5555, 4'b0100);
        rd(32'h10);
        check("ram_lane2", rdata, 32'hDE55_BEEF);
        wr(32'h10, 32'h1234_1234, 4'b0011);
        rd(32'h10);
        check("ram_lane10", rdata, 32'hDE55_1234);

        // Compare match raises irq one cycle after MTIME == MTIMECMP
        wr(TMR + 32'h4, 32'd5, 4'hF);
        wr(TMR + 32'h8, 32'd1, 4'hF);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rd(TMR);
            if (e_rdata == 32'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("mtime_reach5", 32'(found), 32'h1);
        check("irq_at_cmp", 32'(irq), 32'h1);
        wr(TMR + 32'h8, 32'h3, 4'hF);
        check("irq_cleared", 32'(irq), 32'h0);
        rd(TMR + 32'h8);
        check("ctrl_after_w1c", rdata, 32'h1);

        // MTIME wrap
        wr(TMR, 32'hFFFF_FFFE, 4'hF);
        idle();
        idle();
        rd(TMR);
        check("mtime_wrap", rdata, 32'h0);
        check("wrap_no_irq", 32'(irq), 32'h0);

        // Unmapped accesses
        rd(32'h4000_0000);
        check("unmapped_rdata", rdata, 32'h0);
        check("unmapped_err", 32'(err), 32'h1);
        idle();
        check("err_pulse_end", 32'(err), 32'h0);
        wr(32'h4000_0010, 32'hFFFF_FFFF, 4'hF);
        check("unmapped_wr_err", 32'(err), 32'h1);
        rd(32'h10);
        check("ram_untouched", rdata, 32'hDE55_1234);
        rd(TMR + 32'h4);
        check("cmp_untouched", rdata, 32'd5);
        rd(TMR + 32'hC);
        check("rsvd_zero", rdata, 32'h0);

        // Random traffic over a preloaded RAM window, timer and holes
        for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 6)      ra = {26'h0, 4'($urandom), 2'($urandom)};
            else if (kind < 9) ra = TMR | {28'h0, 4'($urandom)};
            else               ra = 32'h4000_0000 | {16'h0, 16'($urandom)};
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), ra, $urandom);
        end

        // Reset during a RAM write with the timer running
        wr(TMR + 32'h4, 32'd3, 4'hF);
        wr(TMR + 32'h8, 32'd1, 4'hF);
        wr(TMR, 32'd0, 4'hF);
        repeat (5) idle();
        check("irq_before_rst", 32'(irq), 32'h1);
        req   = 1'b1;
        we    = 1'b1;
        be    = 4'hF;
        addr  = 32'h24;
        wdata = 32'hCAFE_F00D;
        #3;
        arstn = 1'b1;
        #1;
        check("async_rst_rdata", rdata, 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        check("async_rst_err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        arstn = 1'b0;
        req   = 1'b0;
        model_reset();
        rd(TMR);
        check("mtime_after_rst", rdata, 32'h0);
        rd(TMR + 32'h4);
        check("cmp_after_rst", rdata, 32'hFFFF_FFFF);
        wr(32'h20, 32'hA5A5_3C3C, 4'hF);
        rd(32'h20);
        check("ram_after_rst", rdata, 32'hA5A5_3C3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
